change_dispenser: RTL and testbench
===================================

Name: change_dispenser

Overview:
Money-out counterpart to the vending controller's coin-in path. On a refund or change request it takes a balance in 100-unit steps and drives a coin hopper one coin at a time. Coins are chosen greedily from 1000/500/200/100, and empty hopper tubes are skipped. It handshakes each coin with the hopper and reports completion or failure.

Parameters:
AMT_W, 4, width of amount and remaining, in 100-unit steps.
MAX_AMT, 10, largest legal request (1000).
ACK_TIMEOUT, 255, cycles to wait for eject_ack; used only with the optional feature.

Ports:
clk  in  1  system clock, rising edge.
reset_n  in  1  asynchronous active-low reset.
start  in  1  one-cycle request pulse.
amount  in  AMT_W  balance to dispense, sampled when start is accepted.
coin_empty  in  4  hopper tube empty flags: [3]=1000, [2]=500, [1]=200, [0]=100.
eject_ack  in  1  level signal from the hopper: coin physically ejected.
eject  out  4  one-hot coin eject command, same bit order as coin_empty.
busy  out  1  high from start acceptance until done/fail.
remaining  out  AMT_W  balance not yet dispensed (7-seg feed).
done  out  1  one-cycle pulse, dispense complete.
fail  out  1  one-cycle pulse, dispense aborted; remaining holds the undispensed balance.

Behaviour:
- Reset (async, reset_n low): state IDLE; eject=0, busy=0, remaining=0, done=0, fail=0. All outputs are registered.
- Reset mid-operation aborts immediately. eject drops asynchronously, and no done or fail pulse is produced.
- States: IDLE, SELECT, EJECT, GAP, FINISH.
- IDLE:
  - start=1 with amount<=MAX_AMT: latch remaining=amount, set busy, go to SELECT.
  - start=1 with amount>MAX_AMT: pulse fail next cycle; remaining=amount; busy stays 0.
  - start while busy is ignored.
- SELECT:
  - remaining==0: go to FINISH.
  - Otherwise pick the largest coin c with value(c)<=remaining and coin_empty[c]=0. Values in units: 10, 5, 2, 1.
  - Coin found: register eject=onehot(c), go to EJECT.
  - No coin found: pulse fail, clear busy, go to IDLE; remaining is held.
- EJECT:
  - eject is held stable until eject_ack=1 is sampled.
  - On ack: eject=0, remaining -= value(c), go to GAP.
- GAP: wait until eject_ack=0, then go to SELECT. One coin per full ack high/low cycle, so eject is never reasserted while ack is still high.
- FINISH: pulse done for one cycle, clear busy, go to IDLE. remaining reads 0.
- Latency:
  - start at cycle N: busy=1 at N+1, first eject at N+2.
  - amount=0: done at N+2 with no eject.
- Arithmetic: remaining never underflows (a coin is selected only if value<=remaining). Comparisons are unsigned, width AMT_W.
- coin_empty is sampled only in SELECT; a change during EJECT does not affect the coin in flight.
- done and fail are mutually exclusive and never asserted together with busy=1 in the same cycle.

Optional Feature:
DISPENSE_TIMEOUT_EN
- Defined: a cycle counter runs in EJECT and GAP. If it reaches ACK_TIMEOUT without leaving the state:
  - eject is dropped;
  - fail is pulsed;
  - busy is cleared and the block returns to IDLE;
  - remaining keeps the balance before the stuck coin.
- Undefined: no counter; the block waits on eject_ack indefinitely.

Decomposition:
- Package vm_pkg:
  - coin index constants (COIN_1000=3 … COIN_100=0);
  - coin value table {10,5,2,1};
  - dispenser state typedef;
  - MAX_AMT default.
- One sub-module, coin_select: combinational greedy picker. Inputs remaining and coin_empty; outputs onehot and found. Kept separate so it can be tested exhaustively.

Test Plan:
- amount=9, no tubes empty -> ejects 500, 200, 200 in order, each held until ack; remaining 9→4→2→0; done pulse; fail never asserted.
- amount=8, coin_empty=4'b0100 -> ejects 200 ×4; done; remaining ends 0.
- amount=3, coin_empty=4'b0001 -> one 200 ejected, remaining=1, then fail pulse; busy=0; remaining stays 1.
- amount=11 -> no eject, fail pulse at N+1; amount=0 -> no eject, done at N+2.
- start pulsed again during EJECT with amount=5 -> ignored; the original sequence completes unchanged.
- reset_n low while eject=4'b1000 is waiting for ack -> eject drops immediately, all outputs 0, no done or fail. With DISPENSE_TIMEOUT_EN and ack held low: fail after exactly ACK_TIMEOUT cycles in EJECT.

Source files
------------

// File: rtl/vm_pkg.sv
// Shared vending-machine definitions: coin indices, coin values (in 100-unit steps),
// dispenser FSM states and default sizing.
package vm_pkg;

  localparam int NUM_COINS = 4;

  localparam int COIN_100  = 0;
  localparam int COIN_200  = 1;
  localparam int COIN_500  = 2;
  localparam int COIN_1000 = 3;

  // Indexed by coin index, so COIN_VALUE[COIN_1000] == 10.
  localparam int unsigned COIN_VALUE [NUM_COINS-1:0] = '{10, 5, 2, 1};

  localparam int AMT_W_DEFAULT   = 4;
  localparam int MAX_AMT_DEFAULT = 10;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SELECT,
    ST_EJECT,
    ST_GAP,
    ST_FINISH
  } disp_state_t;

endpackage

// File: rtl/coin_select.sv
// Combinational greedy coin picker: largest non-empty coin whose value fits the
// remaining balance. onehot uses the coin_empty bit order.
module coin_select
  import vm_pkg::*;
#(
  parameter int AMT_W = AMT_W_DEFAULT
) (
  input  logic [AMT_W-1:0]     remaining,
  input  logic [NUM_COINS-1:0] coin_empty,
  output logic [NUM_COINS-1:0] onehot,
  output logic                 found
);

  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    onehot = '0;
    found  = 1'b0;
    for (int i = COIN_1000; i >= COIN_100; i--) begin
      if (!found && !coin_empty[i] && (AMT_W'(COIN_VALUE[i]) <= remaining)) begin
        onehot[i] = 1'b1;
        found     = 1'b1;
      end
    end
  end

endmodule

// File: rtl/change_dispenser.sv
// Change dispenser: pays out a balance one coin at a time through a handshaked hopper.
// Optional build macro DISPENSE_TIMEOUT_EN adds an eject_ack watchdog (ACK_TIMEOUT cycles).
module change_dispenser
  import vm_pkg::*;
#(
  parameter int AMT_W   = AMT_W_DEFAULT,
  parameter int MAX_AMT = MAX_AMT_DEFAULT
`ifdef DISPENSE_TIMEOUT_EN
  ,
  parameter int ACK_TIMEOUT = 255
`endif
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 start,
  input  logic [AMT_W-1:0]     amount,
  input  logic [NUM_COINS-1:0] coin_empty,
  input  logic                 eject_ack,
  output logic [NUM_COINS-1:0] eject,
  output logic                 busy,
  output logic [AMT_W-1:0]     remaining,
  output logic                 done,
  output logic                 fail
);

  disp_state_t          state;
  logic [NUM_COINS-1:0] sel_onehot;
  logic                 sel_found;
  logic [AMT_W-1:0]     coin_val;

  coin_select #(
    .AMT_W(AMT_W)
  ) u_coin_select (
    .remaining (remaining),
    .coin_empty(coin_empty),
    .onehot    (sel_onehot),
    .found     (sel_found)
  );

  // Value of the coin currently in flight, recovered from the one-hot eject register.
  always_comb begin
    coin_val = '0;
    for (int i = 0; i < NUM_COINS; i++) begin
      if (eject[i]) coin_val = AMT_W'(COIN_VALUE[i]);
    end
  end

`ifdef DISPENSE_TIMEOUT_EN
  localparam int TMR_W = $clog2(ACK_TIMEOUT + 1);
  logic [TMR_W-1:0] timer;
  logic             timer_expired;
  assign timer_expired = (timer == TMR_W'(ACK_TIMEOUT - 1));
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= ST_IDLE;
      eject     <= '0;
      busy      <= 1'b0;
      remaining <= '0;
      done      <= 1'b0;
      fail      <= 1'b0;
`ifdef DISPENSE_TIMEOUT_EN
      timer     <= '0;
`endif
    end else begin
      // NOTE: non-blocking assignments throughout, so every branch sees this cycle's values.
      done <= 1'b0;
      fail <= 1'b0;
`ifdef DISPENSE_TIMEOUT_EN
      timer <= '0;
`endif
      unique case (state)
        ST_IDLE: begin
          if (start) begin
            remaining <= amount;
            if (amount <= AMT_W'(MAX_AMT)) begin
              busy  <= 1'b1;
              state <= ST_SELECT;
            end else begin
              fail <= 1'b1;
            end
          end
        end

        ST_SELECT: begin
          // busy drops together with done/fail so they never overlap.
          if (remaining == '0) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= ST_FINISH;
          end else if (sel_found) begin
            eject <= sel_onehot;
            state <= ST_EJECT;
          end else begin
            busy  <= 1'b0;
            fail  <= 1'b1;
            state <= ST_IDLE;
          end
        end

        ST_EJECT: begin
          if (eject_ack) begin
            eject     <= '0;
            remaining <= remaining - coin_val;
            state     <= ST_GAP;
          end
`ifdef DISPENSE_TIMEOUT_EN
          else if (timer_expired) begin
            eject <= '0;
            busy  <= 1'b0;
            fail  <= 1'b1;
            state <= ST_IDLE;
          end else begin
            timer <= timer + 1'b1;
          end
`endif
        end

        ST_GAP: begin
          // Next coin only after the hopper releases ack.
          if (!eject_ack) begin
            state <= ST_SELECT;
          end
`ifdef DISPENSE_TIMEOUT_EN
          else if (timer_expired) begin
            busy  <= 1'b0;
            fail  <= 1'b1;
            state <= ST_IDLE;
          end else begin
            timer <= timer + 1'b1;
          end
`endif
        end

        ST_FINISH: begin
          state <= ST_IDLE;
        end

        default: begin
          eject <= '0;
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_change_dispenser.sv
// Directed, scoreboard-based bench for change_dispenser; a behavioural hopper
// answers each eject and the expected coin sequence is queued at stimulus time.
module tb_change_dispenser;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       start;
  logic [3:0] amount;
  logic [3:0] coin_empty;
  logic       eject_ack;
  logic [3:0] eject;
  logic       busy;
  logic [3:0] remaining;
  logic       done;
  logic       fail;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [3:0] coin;
    logic [3:0] rem;
  } exp_t;

  exp_t sb[$];

  change_dispenser dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .start     (start),
    .amount    (amount),
    .coin_empty(coin_empty),
    .eject_ack (eject_ack),
    .eject     (eject),
    .busy      (busy),
    .remaining (remaining),
    .done      (done),
    .fail      (fail)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int coin_units(input logic [3:0] c);
    case (c)
      4'b1000: return 10;
      4'b0100: return 5;
      4'b0010: return 2;
      4'b0001: return 1;
      default: return 0;
    endcase
  endfunction

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic do_start(input logic [3:0] a);
    amount = a;
    start  = 1'b1;
    tick();
    start  = 1'b0;
    amount = 4'd0;
  endtask

  // Plays the hopper until done/fail, checking each coin against the scoreboard.
  task automatic serve(input logic exp_done, input logic [3:0] exp_final_rem);
    bit   finished = 0;
    int   guard;
    exp_t e;
    while (!finished) begin
      guard = 0;
      while (eject == 4'd0 && !done && !fail && guard < 40) begin
        tick();
        guard++;
      end
      check("wait_bound", guard < 40, 1);
      if (guard >= 40) begin
        finished = 1;
      end else if (eject != 4'd0) begin
        check("coin_expected", sb.size() > 0, 1);
        if (sb.size() == 0) begin
          finished = 1;
        end else begin
          e = sb.pop_front();
          check("coin", eject, e.coin);
          check("rem_before", remaining, e.rem);
          check("busy_during", busy, 1);
          check("no_fail_during", fail, 0);
          repeat (2) begin
            tick();
            check("eject_hold", eject, e.coin);
          end
          eject_ack = 1'b1;
          tick();
          check("eject_drop", eject, 0);
          check("rem_after", remaining, e.rem - coin_units(e.coin));
          tick();
          check("no_reassert", eject, 0);
          eject_ack = 1'b0;
        end
      end else begin
        check("done", done, exp_done);
        check("fail", fail, !exp_done);
        check("busy_end", busy, 0);
        check("rem_final", remaining, exp_final_rem);
        check("coins_left", sb.size(), 0);
        tick();
        check("pulse_len", done | fail, 0);
        check("rem_hold", remaining, exp_final_rem);
        finished = 1;
      end
    end
  endtask

  initial begin
    reset_n    = 1'b0;
    start      = 1'b0;
    amount     = 4'd0;
    coin_empty = 4'd0;
    eject_ack  = 1'b0;
    repeat (2) tick();
    check("rst_eject", eject, 0);
    check("rst_busy", busy, 0);
    check("rst_remaining", remaining, 0);
    check("rst_done", done, 0);
    check("rst_fail", fail, 0);
    reset_n = 1'b1;
    tick();

    // 9 with all tubes full: 500, 200, 200.
    sb.push_back('{4'b0100, 4'd9});
    sb.push_back('{4'b0010, 4'd4});
    sb.push_back('{4'b0010, 4'd2});
    do_start(4'd9);
    check("busy_n1", busy, 1);
    check("eject_n1", eject, 0);
    tick();
    check("first_eject_n2", eject, 4'b0100);
    serve(1'b1, 4'd0);

    // 8 with the 500 tube empty: four 200s.
    coin_empty = 4'b0100;
    for (int i = 0; i < 4; i++) sb.push_back('{4'b0010, 4'(8 - 2 * i)});
    do_start(4'd8);
    serve(1'b1, 4'd0);

    // 3 with the 100 tube empty: one 200 then stuck at 1.
    coin_empty = 4'b0001;
    sb.push_back('{4'b0010, 4'd3});
    do_start(4'd3);
    serve(1'b0, 4'd1);

    // 7 with the 200 tube empty: 500, 100, 100.
    coin_empty = 4'b0010;
    sb.push_back('{4'b0100, 4'd7});
    sb.push_back('{4'b0001, 4'd2});
    sb.push_back('{4'b0001, 4'd1});
    do_start(4'd7);
    serve(1'b1, 4'd0);

    // Boundary 10: a single 1000 coin.
    coin_empty = 4'b0000;
    sb.push_back('{4'b1000, 4'd10});
    do_start(4'd10);
    serve(1'b1, 4'd0);

    // Over-range request: fail at N+1, busy never raised.
    do_start(4'd11);
    check("ovr_fail", fail, 1);
    check("ovr_busy", busy, 0);
    check("ovr_remaining", remaining, 11);
    check("ovr_eject", eject, 0);
    tick();
    check("ovr_fail_pulse", fail, 0);
    check("ovr_rem_hold", remaining, 11);

    // Zero request: done at N+2, no eject.
    do_start(4'd0);
    check("zero_busy_n1", busy, 1);
    check("zero_done_n1", done, 0);
    tick();
    check("zero_done_n2", done, 1);
    check("zero_busy_n2", busy, 0);
    check("zero_eject", eject, 0);
    check("zero_fail", fail, 0);
    tick();
    check("zero_done_pulse", done, 0);

    // Restart during EJECT is ignored; a tube emptying mid-flight leaves the coin alone.
    sb.push_back('{4'b0100, 4'd9});
    sb.push_back('{4'b0010, 4'd4});
    sb.push_back('{4'b0010, 4'd2});
    do_start(4'd9);
    tick();
    check("inj_first_coin", eject, 4'b0100);
    coin_empty = 4'b0100;
    do_start(4'd5);
    check("inj_coin_kept", eject, 4'b0100);
    check("inj_rem_kept", remaining, 9);
    serve(1'b1, 4'd0);
    coin_empty = 4'b0000;

    // Async reset while a 1000 coin waits for ack.
    do_start(4'd10);
    tick();
    check("rstmid_eject_before", eject, 4'b1000);
    #2;
    reset_n = 1'b0;
    #1;
    check("rstmid_eject", eject, 0);
    check("rstmid_busy", busy, 0);
    check("rstmid_remaining", remaining, 0);
    check("rstmid_done", done, 0);
    check("rstmid_fail", fail, 0);
    tick();
    tick();
    reset_n = 1'b1;
    repeat (3) begin
      tick();
      check("rstmid_quiet", {eject, busy, done, fail}, 0);
    end

`ifdef DISPENSE_TIMEOUT_EN
    // Stuck hopper: fail after exactly 255 cycles of eject with no ack.
    begin
      int cnt = 0;
      do_start(4'd10);
      tick();
      while (eject != 4'd0 && cnt < 400) begin
        cnt++;
        tick();
      end
      check("to_cycles", cnt, 255);
      check("to_fail", fail, 1);
      check("to_busy", busy, 0);
      check("to_remaining", remaining, 10);
      tick();
      check("to_fail_pulse", fail, 0);
    end
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
